// File: rtl/avr_trace_buffer.sv
// Execution-trace capture FIFO for the AVR core: samples retired instructions under an
// arm/trigger state machine and drains them through a first-word-fall-through read port.
module avr_trace_buffer #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int OP_W    = 5,
    parameter int DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       arm,
    input  logic                       trig_en,
    input  logic [PC_W-1:0]            trig_pc,
    input  logic                       stop,
    input  logic                       cap_valid,
    input  logic [INSTR_W-1:0]         instruction,
    input  logic [PC_W-1:0]            pc,
    input  logic [DATA_W-1:0]          result,
    input  logic                       cy,
    input  logic                       zy,
    input  logic [OP_W-1:0]            aluop,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [INSTR_W-1:0]         rd_instruction,
    output logic [PC_W-1:0]            rd_pc,
    output logic [DATA_W-1:0]          rd_result,
    output logic                       rd_cy,
    output logic                       rd_zy,
    output logic [OP_W-1:0]            rd_aluop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [1:0]                 state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = INSTR_W + PC_W + DATA_W + 2 + OP_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_plus1;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;
    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [EW-1:0] head_reg;
    logic [EW-1:0] entry_in;

    logic trig_hit;
    logic push_req;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;
    logic arm_accept;

    assign entry_in     = {instruction, pc, result, cy, zy, aluop};
    assign trig_hit     = cap_valid && (pc == trig_pc);
    assign push_req     = ((state_reg == CAPTURE) && cap_valid) ||
                          ((state_reg == ARMED) && trig_hit);
    assign fifo_empty   = (count_reg == '0);
    assign fifo_full    = (count_reg == CW'(DEPTH));
    assign pop          = !fifo_empty && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push         = push_req && (!fifo_full || pop);
    assign drop         = push_req && fifo_full && !pop;
    assign arm_accept   = arm && ((state_reg == IDLE) || (state_reg == DONE));
    assign rd_ptr_plus1 = rd_ptr_reg + AW'(1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (arm) state_next = trig_en ? ARMED : CAPTURE;
            end
            ARMED: begin
                if (stop)          state_next = DONE;
                else if (trig_hit) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (stop) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_plus1;
            if (arm_accept)  overflow_reg <= 1'b0;
            else if (drop)   overflow_reg <= 1'b1;
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr_reg] <= entry_in;
    end

    // Head register precomputes the next visible entry so the read port falls through
    // with one-cycle latency and holds its value while the FIFO is empty or stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg <= '0;
        end else if (!clear) begin
            if (push && (fifo_empty || (pop && count_reg == CW'(1))))
                head_reg <= entry_in;
            else if (pop && count_reg > CW'(1))
                head_reg <= mem[rd_ptr_plus1];
        end
    end

    assign {rd_instruction, rd_pc, rd_result, rd_cy, rd_zy, rd_aluop} = head_reg;
    assign rd_valid = !fifo_empty;
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign state    = state_reg;

endmodule
